// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline hazard/interlock controller for the RV32 core. It sits beside
// decode and tracks the destination registers of the DEPTH instructions in
// flight after decode. From that it derives the decode stall, per-operand
// forwarding selects, branch flush and stage occupancy, and it keeps two
// wrapping performance counters.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   id_valid              decode holds a valid instruction
//   id_rs1/id_rs2         source register indices (+ *_used qualifiers)
//   id_rd/id_rd_en        destination index / writes-rd flag
//   id_is_load            decode instruction is a load
//   br_taken              taken branch/jump resolved in stage 1
//   ext_stall             memory not ready, freeze the whole pipeline
//   id_ready              decode may advance this cycle
//   issue                 decode instruction enters stage 1 at the next edge
//   flush_id              kill fetch/decode contents
//   fwd1_sel/fwd2_sel     0 = register file, k = result of stage k
//   stage_valid           bit k-1 = stage k holds a real instruction
//   stall_cycles          hazard stall cycle counter (wraps)
//   flush_count           flush event counter (wraps)
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_en,
  input  logic                  id_is_load,
  input  logic                  br_taken,
  input  logic                  ext_stall,
  output logic                  id_ready,
  output logic                  issue,
  output logic                  flush_id,
  output logic [SEL_W-1:0]      fwd1_sel,
  output logic [SEL_W-1:0]      fwd2_sel,
  output logic [DEPTH-1:0]      stage_valid,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  // Tracked entries; index k-1 corresponds to stage k.
  logic [DEPTH-1:0]      valid_reg, valid_next;
  logic [DEPTH-1:0]      rd_en_reg, rd_en_next;
  logic [DEPTH-1:0]      load_reg,  load_next;
  logic [REG_ADDR_W-1:0] rd_reg  [DEPTH];
  logic [REG_ADDR_W-1:0] rd_next [DEPTH];
  logic [31:0]           stall_cycles_reg, flush_count_reg;

  logic [DEPTH-1:0] match1, match2;
  logic [SEL_W-1:0] sel1, sel2;
  logic             ld1, ld2;
  logic             use1, use2;
  logic             haz1, haz2, hazard;

  genvar gi;

  // Per-stage register match against both source operands.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match1[gi] = valid_reg[gi] & rd_en_reg[gi] & (rd_reg[gi] == id_rs1);
      assign match2[gi] = valid_reg[gi] & rd_en_reg[gi] & (rd_reg[gi] == id_rs2);
    end
  endgenerate

  // Scan from the oldest stage to the youngest so the youngest match
  // (smallest k) is the one left standing.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    ld1  = 1'b0;
    ld2  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match1[k-1]) begin
        sel1 = SEL_W'(k);
        ld1  = load_reg[k-1] && (k < LOAD_STAGE);
      end
      if (match2[k-1]) begin
        sel2 = SEL_W'(k);
        ld2  = load_reg[k-1] && (k < LOAD_STAGE);
      end
    end
  end

  assign use1 = id_rs1_used && (id_rs1 != '0);
  assign use2 = id_rs2_used && (id_rs2 != '0);
  assign haz1 = use1 && ld1;
  assign haz2 = use2 && ld2;

  // A load that is not yet forwardable yields select 0 (no usable source).
  assign fwd1_sel = (use1 && !ld1) ? sel1 : '0;
  assign fwd2_sel = (use2 && !ld2) ? sel2 : '0;

  assign hazard   = id_valid && (haz1 || haz2);
  assign id_ready = !ext_stall && !hazard;
  assign flush_id = br_taken && !ext_stall;
  assign issue    = id_valid && id_ready && !br_taken;

  // Stage 1 receives the decode instruction or a bubble; x0 destinations are
  // stored as non-writing so they never match.
  assign valid_next[0] = issue;
  assign rd_en_next[0] = issue && id_rd_en && (id_rd != '0);
  assign load_next[0]  = issue && id_is_load;
  assign rd_next[0]    = id_rd;

  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign valid_next[gi] = valid_reg[gi-1];
      assign rd_en_next[gi] = rd_en_reg[gi-1];
      assign load_next[gi]  = load_reg[gi-1];
      assign rd_next[gi]    = rd_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg        <= '0;
      rd_en_reg        <= '0;
      load_reg         <= '0;
      for (int i = 0; i < DEPTH; i++) rd_reg[i] <= '0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else if (!ext_stall) begin
      valid_reg <= valid_next;
      rd_en_reg <= rd_en_next;
      load_reg  <= load_next;
      rd_reg    <= rd_next;
      // A taken branch overrides the stall, so it is not counted.
      if (hazard && !br_taken) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (br_taken)            flush_count_reg  <= flush_count_reg + 32'd1;
    end
  end

  assign stage_valid  = valid_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with DEPTH = 3, LOAD_STAGE = 2.
module tb_hazard_unit;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used, id_rd_en, id_is_load;
  logic          br_taken, ext_stall;
  logic          id_ready, issue, flush_id;
  logic [SW-1:0] fwd1_sel, fwd2_sel;
  logic [D-1:0]  stage_valid;
  logic [31:0]   stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  hazard_unit #(.REG_ADDR_W(AW), .DEPTH(D), .LOAD_STAGE(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_en(id_rd_en), .id_is_load(id_is_load),
    .br_taken(br_taken), .ext_stall(ext_stall),
    .id_ready(id_ready), .issue(issue), .flush_id(flush_id),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .stage_valid(stage_valid), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point sits 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_en = 0; id_is_load = 0; br_taken = 0; ext_stall = 0;
  endtask

  // Drive a decode instruction (no operands) and let it settle.
  task automatic drive_wr(input logic [AW-1:0] rd, input logic en, input logic ld);
    idle();
    id_valid = 1; id_rd = rd; id_rd_en = en; id_is_load = ld;
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    #1;
    $display("reset release");
    chk("rst_stage_valid", 32'(stage_valid), 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_flush_count", flush_count, 0);
    chk("rst_fwd1", 32'(fwd1_sel), 0);
    chk("rst_id_ready", 32'(id_ready), 1);

    // ALU chain: addi x5 then a reader of x5 for four cycles
    $display("alu chain");
    drive_wr(5'd5, 1, 0);
    chk("alu_issue", 32'(issue), 1);
    step();
    idle();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    #1;
    chk("alu_fwd_c1", 32'(fwd1_sel), 1);
    chk("alu_ready_c1", 32'(id_ready), 1);
    step(); chk("alu_fwd_c2", 32'(fwd1_sel), 2); chk("alu_ready_c2", 32'(id_ready), 1);
    step(); chk("alu_fwd_c3", 32'(fwd1_sel), 3); chk("alu_ready_c3", 32'(id_ready), 1);
    step(); chk("alu_fwd_c4", 32'(fwd1_sel), 0); chk("alu_ready_c4", 32'(id_ready), 1);

    // Drain, then load-use
    idle(); step(); step(); step();
    chk("drain_stage_valid", 32'(stage_valid), 0);
    $display("load use");
    drive_wr(5'd5, 1, 1);
    step();
    idle();
    id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_rs1_used = 1; id_rs2_used = 1;
    id_rd = 6; id_rd_en = 1;
    #1;
    chk("lu_ready_c1", 32'(id_ready), 0);
    chk("lu_issue_c1", 32'(issue), 0);
    chk("lu_fwd1_c1", 32'(fwd1_sel), 0);
    chk("lu_stage_valid_c1", 32'(stage_valid), 3'b001);
    step();
    chk("lu_stall_cycles", stall_cycles, 1);
    chk("lu_stage_valid_c2", 32'(stage_valid), 3'b010);
    chk("lu_fwd1_c2", 32'(fwd1_sel), 2);
    chk("lu_fwd2_c2", 32'(fwd2_sel), 2);
    chk("lu_issue_c2", 32'(issue), 1);
    step();
    idle(); step(); step(); step();

    // Priority: x7 writers in stages 1 and 3
    $display("priority and x0");
    drive_wr(5'd7, 1, 0); step();
    drive_wr(5'd8, 0, 0); step();
    drive_wr(5'd7, 1, 0); step();
    idle();
    id_rs1 = 7; id_rs1_used = 1; id_rs2 = 7; id_rs2_used = 1;
    #1;
    chk("prio_fwd1", 32'(fwd1_sel), 1);
    chk("prio_fwd2_same", 32'(fwd2_sel), 1);
    drive_wr(5'd0, 1, 0); step();
    idle();
    id_rs1 = 0; id_rs1_used = 1;
    #1;
    chk("x0_fwd1", 32'(fwd1_sel), 0);
    id_rs1 = 7;
    #1;
    chk("x0_skip_fwd1", 32'(fwd1_sel), 2);

    // Branch flush
    $display("branch flush");
    drive_wr(5'd9, 1, 0);
    br_taken = 1;
    #1;
    chk("br_issue", 32'(issue), 0);
    chk("br_flush_id", 32'(flush_id), 1);
    step();
    idle();
    #1;
    chk("br_stage0", 32'(stage_valid[0]), 0);
    chk("br_flush_count", flush_count, 1);
    drive_wr(5'd10, 1, 1); step();
    idle();
    id_valid = 1; id_rs1 = 10; id_rs1_used = 1; br_taken = 1;
    #1;
    chk("brh_flush_id", 32'(flush_id), 1);
    chk("brh_ready", 32'(id_ready), 0);
    chk("brh_issue", 32'(issue), 0);
    step();
    idle();
    #1;
    chk("brh_stall_cycles", stall_cycles, 1);
    chk("brh_flush_count", flush_count, 2);
    chk("brh_stage0", 32'(stage_valid[0]), 0);

    // ext_stall freeze
    $display("ext stall");
    drive_wr(5'd11, 1, 0); step();
    drive_wr(5'd12, 1, 0); step();
    drive_wr(5'd13, 1, 0); step();
    idle();
    id_valid = 1; id_rs1 = 12; id_rs1_used = 1; id_rd = 14; id_rd_en = 1;
    br_taken = 1; ext_stall = 1;
    #1;
    chk("es_issue", 32'(issue), 0);
    chk("es_flush_id", 32'(flush_id), 0);
    chk("es_ready", 32'(id_ready), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("es_stage_valid", 32'(stage_valid), 3'b111);
      chk("es_fwd1", 32'(fwd1_sel), 2);
      chk("es_flush_count", flush_count, 2);
      chk("es_stall_cycles", stall_cycles, 1);
    end
    ext_stall = 0; br_taken = 0; id_valid = 0;
    #1;
    chk("es_rel_issue", 32'(issue), 0);
    step();
    chk("es_resume_stage_valid", 32'(stage_valid), 3'b110);
    chk("es_resume_fwd1", 32'(fwd1_sel), 3);

    // Reset mid-stall discards everything
    $display("reset mid stall");
    ext_stall = 1; br_taken = 1;
    reset = 1;
    step();
    reset = 0; idle();
    #1;
    chk("rst2_stage_valid", 32'(stage_valid), 0);
    chk("rst2_flush_count", flush_count, 0);
    chk("rst2_stall_cycles", stall_cycles, 0);
    chk("rst2_ready", 32'(id_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
